scope_capture_ctrl: RTL and testbench
=====================================

Name: scope_capture_ctrl

Overview:
- Sequences the 12-bit x 32-word sample BRAM (blk_mem_gen_0 instance) for the oscilloscope datapath.
- Once armed, it writes ADC samples into the BRAM as a circular buffer and watches for a level-crossing trigger.
- After the trigger it captures a fixed number of post-trigger samples, then streams the buffer out oldest-first over a valid/ready port.
- Sits between the ADC sample stream and the readout/transfer logic; it is the only BRAM master.

Parameters:
- DATA_W, 12, sample and BRAM data width.
- ADDR_W, 5, BRAM address width; DEPTH = 2**ADDR_W = 32.
- POST_TRIG, 16, samples stored from the trigger sample onwards (1..DEPTH-1); PRE = DEPTH-POST_TRIG.

Ports:
- clk  in  1  system clock; BRAM is clocked on ~clk by the instantiating level.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  ADC sample, unsigned.
- arm  in  1  one-cycle pulse; starts a capture when idle.
- abort  in  1  one-cycle pulse; cancels capture or readout.
- trig_level  in  DATA_W  trigger threshold, unsigned; sampled on arm.
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger; sampled on arm.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data; valid 1 cycle after the address is presented.
- rd_valid  out  1  readout word is valid.
- rd_ready  in  1  downstream accepts the readout word.
- rd_data  out  DATA_W  readout word.
- rd_last  out  1  marks the final (DEPTH-th) readout word.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  trigger accepted; held high until the controller returns to IDLE.
- done  out  1  one-cycle pulse when the last readout word is accepted.

Behaviour:
- Reset: all outputs 0, state IDLE, wr_ptr/rd_ptr/counters 0. Reset takes effect asynchronously, including mid-capture and mid-readout.
- BRAM outputs are registered. A sample accepted in cycle n gives bram_we=1 with bram_addr=wr_ptr and bram_din=sample in cycle n+1.
- States:
  - IDLE: arm -> FILL. In the same cycle, latch trig_level and trig_rising, clear fill_cnt, post_cnt and prev_valid. wr_ptr is not cleared.
  - FILL: each accepted sample is written and wr_ptr increments (wraps DEPTH-1 -> 0). fill_cnt increments, saturating at PRE. When fill_cnt reaches PRE -> ARMED.
  - ARMED: samples continue to be written. On a trigger-condition sample: set triggered, post_cnt=1, -> POST if POST_TRIG>1, else -> RD_ISSUE. The trigger sample itself is written.
  - POST: each accepted sample is written and post_cnt increments. The sample that makes post_cnt = POST_TRIG is written, then -> RD_ISSUE with rd_ptr = wr_ptr after that write (the oldest sample) and rd_cnt=0.
  - RD_ISSUE: drive bram_addr=rd_ptr, bram_we=0 -> RD_WAIT.
  - RD_WAIT: at the end of this cycle rd_data <= bram_dout -> RD_OUT.
  - RD_OUT: rd_valid=1; rd_last=1 when rd_cnt = DEPTH-1. rd_data, rd_valid and rd_last stay stable while rd_ready=0. On rd_valid & rd_ready:
    - if last: done pulse next cycle, -> IDLE;
    - otherwise rd_ptr+1 (wrapping), rd_cnt+1, -> RD_ISSUE.
  - Readout throughput: at most 1 word per 3 cycles.
- Trigger condition (unsigned compare; prev = previous accepted sample since arm):
  - rising: prev_valid & prev < level & cur >= level.
  - falling: prev_valid & prev > level & cur <= level.
  - The first sample after arm can never trigger.
  - Crossings in FILL are ignored, but prev is still updated.
- sample_valid gaps: no state or pointer changes. sample_valid is ignored in IDLE and in RD_* states.
- Readout word k (0-based) = k-th oldest sample; the trigger sample is at index PRE.
- arm while busy: ignored. abort: -> IDLE next cycle; triggered, rd_valid, rd_last and busy go to 0; no done pulse. abort has priority over arm and rd_ready in the same cycle.
- done and busy: in the cycle the done pulse is high, busy=0.

Decomposition:
- Shared package/include: state encoding constants (IDLE, FILL, ARMED, POST, RD_ISSUE, RD_WAIT, RD_OUT), DATA_W/ADDR_W defaults, DEPTH localparam.
- One sub-module: scope_trig_detect.
  - Inputs: clk, rst, clear, sample_valid, sample, level, rising.
  - Output: hit (combinational on the current sample).
  - Holds the prev/prev_valid registers.

Test Plan:
- Ramp 0,1,2,..., level=100, rising, DEPTH=32, POST_TRIG=16 -> triggered on sample 100. Readout is 84..115, rd_last on 115, one done pulse, busy low after.
- Sawtooth 0..19 repeating, level=5, rising -> crossing at sample index 5 ignored (FILL); trigger at index 25. Readout: 9..19, 0..19, 0; word 16 = 5.
- Ramp down from 4095, level=4000, falling, with sample_valid low every other cycle -> trigger on 4000. Readout is 4016 down to 3985.
- Same as the first scenario but rd_ready low for 10 cycles at word 3 -> rd_valid stays 1 and rd_data stays 87 throughout; no skipped or duplicated word.
- abort during POST -> IDLE next cycle, triggered=0, no rd_valid, no done. A following arm then completes a normal capture.
- Assert rst mid-RD_OUT, not aligned to clk -> all outputs 0 immediately. A later arm captures correctly.

Source files
------------

// File: rtl/scope_capture_ctrl_pkg.sv
// Shared constants for the oscilloscope capture controller: state encoding
// and default datapath geometry.
`timescale 1ns/1ps
package scope_capture_ctrl_pkg;

  localparam int DEFAULT_DATA_W = 12;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] ARMED    = 3'd2;
  localparam logic [2:0] POST     = 3'd3;
  localparam logic [2:0] RD_ISSUE = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] RD_OUT   = 3'd6;

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing trigger detector: remembers the previous accepted sample and
// flags the current one when it crosses the threshold in the chosen direction.
`timescale 1ns/1ps
module scope_trig_detect #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              rising,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  // NOTE: hit is assigned on every path, so no latch is inferred.
  always_comb begin
    if (rising) hit = prev_valid && (prev < level) && (sample >= level);
    else        hit = prev_valid && (prev > level) && (sample <= level);
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Capture sequencer for the scope sample BRAM: circular pre-trigger fill,
// level trigger, fixed post-trigger capture, then oldest-first readout.
`timescale 1ns/1ps
module scope_capture_ctrl
  import scope_capture_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int POST_TRIG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PRE   = DEPTH - POST_TRIG;
  localparam logic [ADDR_W-1:0] PRE_CNT  = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] POST_CNT = ADDR_W'(POST_TRIG);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_next;
  logic [ADDR_W-1:0] fill_cnt, post_cnt, rd_cnt;
  logic [DATA_W-1:0] level;
  logic              rising;
  logic              accept, trig_clear, hit;

  assign wr_next    = wr_ptr + 1'b1;
  assign accept     = sample_valid && !abort &&
                      (state == FILL || state == ARMED || state == POST);
  assign trig_clear = (state == IDLE) && arm && !abort;

  assign busy     = (state != IDLE);
  assign rd_valid = (state == RD_OUT);
  assign rd_last  = rd_valid && (rd_cnt == LAST_CNT);

  scope_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk          (clk),
    .rst          (rst),
    .clear        (trig_clear),
    .sample_valid (accept),
    .sample       (sample_data),
    .level        (level),
    .rising       (rising),
    .hit          (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      level     <= '0;
      rising    <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      rd_data   <= '0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        bram_we   <= 1'b1;
        bram_addr <= wr_ptr;
        bram_din  <= sample_data;
        wr_ptr    <= wr_next;
      end
      if (abort) begin
        state     <= IDLE;
        triggered <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            state    <= FILL;
            level    <= trig_level;
            rising   <= trig_rising;
            fill_cnt <= '0;
            post_cnt <= '0;
          end
          FILL: if (accept) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt + 1'b1 == PRE_CNT) state <= ARMED;
          end
          ARMED: if (accept && hit) begin
            triggered <= 1'b1;
            post_cnt  <= ADDR_W'(1);
            if (POST_TRIG > 1) begin
              state <= POST;
            end else begin
              state  <= RD_ISSUE;
              rd_ptr <= wr_next;
              rd_cnt <= '0;
            end
          end
          POST: if (accept) begin
            post_cnt <= post_cnt + 1'b1;
            // The write pointer after this sample lands on the oldest word.
            if (post_cnt + 1'b1 == POST_CNT) begin
              state  <= RD_ISSUE;
              rd_ptr <= wr_next;
              rd_cnt <= '0;
            end
          end
          RD_ISSUE: begin
            bram_addr <= rd_ptr;
            state     <= RD_WAIT;
          end
          RD_WAIT: begin
            rd_data <= bram_dout;
            state   <= RD_OUT;
          end
          RD_OUT: if (rd_ready) begin
            if (rd_cnt == LAST_CNT) begin
              done      <= 1'b1;
              triggered <= 1'b0;
              state     <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              rd_cnt <= rd_cnt + 1'b1;
              state  <= RD_ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl with a negedge-clocked BRAM model,
// a sample source process and table-driven capture scenarios.
`timescale 1ns/1ps
module tb_scope_capture_ctrl;

  localparam int DATA_W    = 12;
  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 32;
  localparam int POST_TRIG = 16;

  logic              clk, rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              arm, abort;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last, busy, triggered, done;

  scope_capture_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .abort(abort),
    .trig_level(trig_level), .trig_rising(trig_rising),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model clocked on the falling edge, read-first.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(negedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  int done_cnt = 0;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Sample source: kind 0 = ramp up, 1 = sawtooth 0..19, 2 = ramp down from 4095.
  bit src_en    = 1'b0;
  bit src_gap   = 1'b0;
  bit src_phase = 1'b0;
  int src_kind  = 0;
  int src_idx   = 0;

  function automatic logic [DATA_W-1:0] src_val(input int kind, input int idx);
    case (kind)
      1:       return DATA_W'(idx % 20);
      2:       return DATA_W'(4095 - idx);
      default: return DATA_W'(idx);
    endcase
  endfunction

  initial begin
    sample_valid = 1'b0;
    sample_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (src_en) begin
        if (src_gap && src_phase) begin
          sample_valid = 1'b0;
        end else begin
          sample_valid = 1'b1;
          sample_data  = src_val(src_kind, src_idx);
          src_idx++;
        end
        src_phase = !src_phase;
      end else begin
        sample_valid = 1'b0;
      end
    end
  end

  typedef struct {
    string name;
    int    kind;
    int    level;
    bit    rising;
    bit    gap;
    int    stall_word;
    int    stall_len;
    int    exp_first;
    int    exp_step;
    int    exp_mod;
  } vec_t;

  vec_t vecs [4];

  function automatic int exp_word(input vec_t v, input int k);
    int e;
    e = v.exp_first + v.exp_step * k;
    return ((e % v.exp_mod) + v.exp_mod) % v.exp_mod;
  endfunction

  task automatic start_capture(input vec_t v);
    @(posedge clk);
    #1;
    src_en      = 1'b0;
    src_idx     = 0;
    src_phase   = 1'b0;
    src_kind    = v.kind;
    src_gap     = v.gap;
    trig_level  = DATA_W'(v.level);
    trig_rising = v.rising;
    rd_ready    = 1'b1;
    arm         = 1'b1;
    @(posedge clk);
    #1;
    arm         = 1'b0;
    trig_level  = '0;
    trig_rising = ~v.rising;
    src_en      = 1'b1;
  endtask

  task automatic wait_rd_valid(input string name, output bit ok);
    int n = 0;
    while (rd_valid !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (rd_valid === 1'b1);
    if (!ok) check({name, "_rd_valid_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int k, cyc, stall, done_before;
    start_capture(v);
    wait_rd_valid(v.name, ok);
    if (!ok) begin
      src_en = 1'b0;
      return;
    end
    check({v.name, "_triggered"}, triggered, 1);
    check({v.name, "_busy_rd"}, busy, 1);
    done_before = done_cnt;
    k = 0; cyc = 0; stall = 0;
    while (k < DEPTH && cyc < 500) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      cyc++;
      if (rd_valid === 1'b1) begin
        if (k == v.stall_word && stall < v.stall_len) begin
          rd_ready = 1'b0;
          stall++;
          check($sformatf("%s_stall_data%0d", v.name, stall), rd_data, exp_word(v, k));
        end else begin
          rd_ready = 1'b1;
          check($sformatf("%s_word%0d", v.name, k), rd_data, exp_word(v, k));
          check($sformatf("%s_last%0d", v.name, k), rd_last, (k == DEPTH - 1));
          k++;
        end
      end else begin
        rd_ready = 1'b1;
      end
    end
    check({v.name, "_word_count"}, k, DEPTH);
    @(posedge clk);
    #1;
    check({v.name, "_done_pulse"}, done, 1);
    check({v.name, "_busy_at_done"}, busy, 0);
    check({v.name, "_trig_cleared"}, triggered, 0);
    @(posedge clk);
    #1;
    check({v.name, "_done_one_cycle"}, done, 0);
    check({v.name, "_done_count"}, done_cnt - done_before, 1);
    src_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, seen_valid, done_before;

    vecs[0] = '{"ramp_up",    0,  100, 1'b1, 1'b0, -1,  0,   84,  1, 4096};
    vecs[1] = '{"sawtooth",   1,    5, 1'b1, 1'b0, -1,  0,    9,  1,   20};
    vecs[2] = '{"ramp_down",  2, 4000, 1'b0, 1'b1, -1,  0, 4016, -1, 4096};
    vecs[3] = '{"ramp_stall", 0,  100, 1'b1, 1'b0,  3, 10,   84,  1, 4096};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    trig_level = '0; trig_rising = 1'b0;
    #12;
    check("reset_outputs",
          {bram_we, bram_addr, bram_din, rd_valid, rd_data, rd_last, busy, triggered, done}, 0);
    #11 rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort while collecting post-trigger samples.
    start_capture(vecs[0]);
    n = 0;
    while (triggered !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_pre_triggered", triggered, 1);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_triggered", triggered, 0);
    done_before = done_cnt;
    seen_valid  = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (rd_valid === 1'b1) seen_valid++;
    end
    check("abort_no_rd_valid", seen_valid, 0);
    check("abort_no_done", done_cnt - done_before, 0);
    src_en = 1'b0;
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of readout.
    start_capture(vecs[0]);
    wait_rd_valid("rst_mid", ok);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          {bram_we, bram_addr, bram_din, rd_valid, rd_data, rd_last, busy, triggered, done}, 0);
    src_en = 1'b0;
    #13 rst = 1'b0;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
